// File: rtl/cdb_pkg.sv
// Shared CDB writeback definitions: lane geometry and the packed writeback entry
// carried from the MEM unit through its CDB queue.
package cdb_pkg;

    localparam int NUM_LANES = 8;
    localparam int LANE_W    = 32;
    localparam int WARP_W    = 3;
    localparam int SCBID_W   = 2;
    localparam int DST_W     = 5;
    localparam int INSTR_W   = 32;

    typedef struct packed {
        logic [WARP_W-1:0]           warp;
        logic                        regwrite;
        logic [DST_W-1:0]            dst;
        logic [NUM_LANES*LANE_W-1:0] data;
        logic [INSTR_W-1:0]          instr;
        logic [NUM_LANES-1:0]        mask;
        logic [SCBID_W-1:0]          scbid;
    } wb_entry_t;

endpackage

// File: rtl/sync_fifo_flat.sv
// Flat synchronous FIFO with registered count and pointers; the head is read
// straight out of storage at the read pointer.
module sync_fifo_flat #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_cdb_writeback_queue.sv
// MEM-to-CDB writeback queue: buffers MEM results, drains only when the ALU
// leaves the CDB free, and asks the ALU to back off when the head starves.
module mem_cdb_writeback_queue
    import cdb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Valid_MEM_MEMQ,
    output logic                         Ready_MEMQ_MEM,
    input  logic [WARP_W-1:0]            WarpID_MEM_MEMQ,
    input  logic                         RegWrite_MEM_MEMQ,
    input  logic [DST_W-1:0]             Dst_MEM_MEMQ,
    input  logic [NUM_LANES*LANE_W-1:0]  Dst_Data_MEM_MEMQ,
    input  logic [INSTR_W-1:0]           Instr_MEM_MEMQ,
    input  logic [NUM_LANES-1:0]         ActiveMask_MEM_MEMQ,
    input  logic [SCBID_W-1:0]           ScbID_MEM_MEMQ,
    input  logic                         RegWrite_ALU_CDB,
    output logic [WARP_W-1:0]            WarpID_MEM_CDB,
    output logic                         RegWrite_MEM_CDB,
    output logic [DST_W-1:0]             Dst_MEM_CDB,
    output logic [NUM_LANES*LANE_W-1:0]  Dst_Data_MEM_CDB,
    output logic [INSTR_W-1:0]           Instr_MEM_CDB,
    output logic [NUM_LANES-1:0]         ActiveMask_MEM_CDB,
    output logic [SCBID_W-1:0]           Clear_ScbID_MEM_CDB,
    output logic                         Starve_MEMQ_ALU,
    output logic [$clog2(DEPTH):0]       Count_MEMQ
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(STARVE_LIMIT) + 1;

    typedef enum logic {IDLE, PEND} state_t;

    state_t          state;
    state_t          state_next;
    wb_entry_t       in_entry;
    wb_entry_t       head;
    logic            full;
    logic            push;
    logic            pop;
    logic [WW-1:0]   wait_cnt;

    assign Ready_MEMQ_MEM = ~full;
    // Writebacks without a register write are accepted but never occupy a slot.
    assign push = Valid_MEM_MEMQ & ~full & RegWrite_MEM_MEMQ;

    assign in_entry = '{warp:     WarpID_MEM_MEMQ,
                        regwrite: RegWrite_MEM_MEMQ,
                        dst:      Dst_MEM_MEMQ,
                        data:     Dst_Data_MEM_MEMQ,
                        instr:    Instr_MEM_MEMQ,
                        mask:     ActiveMask_MEM_MEMQ,
                        scbid:    ScbID_MEM_MEMQ};

    sync_fifo_flat #(
        .WIDTH($bits(wb_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head),
        .count (Count_MEMQ),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (push) state_next = PEND;
            end
            PEND: begin
                pop = ~RegWrite_ALU_CDB;
                if (pop && !push && Count_MEMQ == CW'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Starve drops the cycle after the pop, even though wait_cnt was saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt        <= '0;
            Starve_MEMQ_ALU <= 1'b0;
        end else begin
            if (pop || state == IDLE) begin
                wait_cnt <= '0;
            end else if (RegWrite_ALU_CDB && wait_cnt != WW'(STARVE_LIMIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            Starve_MEMQ_ALU <= (state == PEND) && !pop && (wait_cnt == WW'(STARVE_LIMIT));
        end
    end

    assign RegWrite_MEM_CDB    = (state == PEND) & head.regwrite;
    assign WarpID_MEM_CDB      = head.warp;
    assign Dst_MEM_CDB         = head.dst;
    assign Dst_Data_MEM_CDB    = head.data;
    assign Instr_MEM_CDB       = head.instr;
    assign ActiveMask_MEM_CDB  = head.mask;
    assign Clear_ScbID_MEM_CDB = head.scbid;

endmodule
